// File: rtl/buf_pipe_chain.sv
`default_nettype none
// ============================================================================
// Module   : buf_pipe_chain
// Brief    : WIDTH-bit, DEPTH-stage elastic valid/ready pipeline with a
//            per-bit buffer/inverter mask applied at stage 0.
// Revision : 1.0 - initial release
// ============================================================================
module buf_pipe_chain #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 2,
  parameter logic [WIDTH-1:0] INV_MASK = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             r_v [DEPTH];
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [DEPTH:0]   w_rdy;
  logic [OCC_W-1:0] w_occ;

  assign w_rdy[DEPTH] = out_ready;

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic             w_in_v;
      logic [WIDTH-1:0] w_in_d;

      // A stage may take a new word when it is empty or its successor moves.
      assign w_rdy[k] = ~r_v[k] | w_rdy[k+1];

      if (k == 0) begin : g_head
        assign w_in_v = in_valid & ~flush;
        assign w_in_d = in_data ^ INV_MASK;
      end else begin : g_body
        assign w_in_v = r_v[k-1];
        assign w_in_d = r_d[k-1];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_v[k] <= 1'b0;
          r_d[k] <= '0;
        end else begin
          if (flush) begin
            r_v[k] <= 1'b0;
          end else if (w_rdy[k]) begin
            r_v[k] <= w_in_v;
          end
          // Data enable is qualified by the incoming valid to avoid idle toggling.
          if (w_rdy[k] && w_in_v) begin
            r_d[k] <= w_in_d;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    w_occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_occ = w_occ + OCC_W'(r_v[k]);
    end
  end

  assign in_ready  = w_rdy[0] & ~flush;
  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];
  assign occupancy = w_occ;

endmodule
`default_nettype wire
